// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: registered entry sequence for the board ALU.
// The user loads operand A, then operand B, then picks an operation with one button pulse.
// The sequencer drives A, B, a one-hot opcode and a stage indicator for the display top.
// Optional feature macro: ALU_SEQ_HOLD_TIMEOUT_EN.
//   When it is defined, the opcode is cleared after HOLD_CYCLES cycles in SHOW.
//   When it is undefined, no hold counter is built and SHOW is held until a load or a clear.
module alu_operand_sequencer #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned HOLD_CYCLES = 100000000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw,
   input  logic             load_pulse,
   input  logic             clear_pulse,
   input  logic [3:0]       op_pulse,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic [3:0]       opcode,
   output logic [1:0]       stage,
   output logic             exec_valid
);

   typedef enum logic [1:0] {
      S_LOAD_A = 2'd0,
      S_LOAD_B = 2'd1,
      S_OP     = 2'd2,
      S_SHOW   = 2'd3
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] a_d;
   logic [WIDTH-1:0] b_d;
   logic [3:0]       opcode_d;
   logic             exec_d;
   logic             op_valid;
   logic             expire;

   // Reject a hold period too short for the counter to make sense
   if (HOLD_CYCLES < 2) begin : g_hold_check
      $error("alu_operand_sequencer: HOLD_CYCLES must be at least 2");
   end

   // Accept an operation only when exactly one button bit is set
   assign op_valid = (op_pulse != 4'd0) && ((op_pulse & (op_pulse - 4'd1)) == 4'd0);

`ifdef ALU_SEQ_HOLD_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // The hold period ends in the SHOW cycle where the counter reads HOLD_CYCLES-1
   assign expire = (state_q == S_SHOW) && (cnt_q == CNT_W'(HOLD_CYCLES - 1));

   // The counter advances only on an idle SHOW cycle and stays at zero otherwise
   always_comb begin
      cnt_d = '0;
      if (!clear_pulse && (state_q == S_SHOW) && !load_pulse && !op_valid && !expire) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Register for the hold counter
   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign expire = 1'b0;
`endif

   // Register for the state
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_LOAD_A;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state. Clear has the highest priority, then load, then a valid op, then expiry.
   always_comb begin
      state_d = state_q;
      if (clear_pulse) begin
         state_d = S_LOAD_A;
      end else begin
         case (state_q)
            S_LOAD_A: if (load_pulse) state_d = S_LOAD_B;
            S_LOAD_B: if (load_pulse) state_d = S_OP;
            S_OP: begin
               if (load_pulse)    state_d = S_LOAD_B;
               else if (op_valid) state_d = S_SHOW;
            end
            S_SHOW: begin
               if (load_pulse)    state_d = S_LOAD_B;
               else if (op_valid) state_d = S_SHOW;
               else if (expire)   state_d = S_LOAD_A;
            end
            default: state_d = S_LOAD_A;
         endcase
      end
   end

   // Next values for the output registers, using the same event priority
   always_comb begin
      a_d      = A;
      b_d      = B;
      opcode_d = opcode;
      exec_d   = 1'b0;
      if (clear_pulse) begin
         a_d      = '0;
         b_d      = '0;
         opcode_d = 4'd0;
      end else begin
         case (state_q)
            S_LOAD_A: if (load_pulse) a_d = sw;
            S_LOAD_B: if (load_pulse) b_d = sw;
            S_OP: begin
               if (load_pulse) begin
                  a_d = sw;
               end else if (op_valid) begin
                  opcode_d = op_pulse;
                  exec_d   = 1'b1;
               end
            end
            S_SHOW: begin
               if (load_pulse) begin
                  a_d      = sw;
                  opcode_d = 4'd0;
               end else if (op_valid) begin
                  opcode_d = op_pulse;
                  exec_d   = 1'b1;
               end else if (expire) begin
                  opcode_d = 4'd0;
               end
            end
            default: ;
         endcase
      end
   end

   // Registers for the output signals
   always_ff @(posedge clk) begin
      if (!rst) begin
         A          <= '0;
         B          <= '0;
         opcode     <= 4'd0;
         exec_valid <= 1'b0;
      end else begin
         A          <= a_d;
         B          <= b_d;
         opcode     <= opcode_d;
         exec_valid <= exec_d;
      end
   end

   assign stage = state_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb_alu_operand_sequencer: directed vectors for the ALU operand sequencer, using HOLD_CYCLES=10.
module tb_alu_operand_sequencer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned HOLD  = 10;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] sw;
   logic             load_pulse;
   logic             clear_pulse;
   logic [3:0]       op_pulse;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       opcode;
   logic [1:0]       stage;
   logic             exec_valid;

   int n_checks;
   int n_pass;

   alu_operand_sequencer #(
      .WIDTH       (WIDTH),
      .HOLD_CYCLES (HOLD)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .sw          (sw),
      .load_pulse  (load_pulse),
      .clear_pulse (clear_pulse),
      .op_pulse    (op_pulse),
      .A           (A),
      .B           (B),
      .opcode      (opcode),
      .stage       (stage),
      .exec_valid  (exec_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Drive the pulses for one cycle, then sample 1 ns after the edge
   task automatic step(input logic ld, input logic clr, input logic [3:0] op);
      load_pulse  = ld;
      clear_pulse = clr;
      op_pulse    = op;
      @(posedge clk);
      #1;
      load_pulse  = 1'b0;
      clear_pulse = 1'b0;
      op_pulse    = 4'd0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0);
   endtask

   task automatic load_sw(input logic [WIDTH-1:0] v);
      sw = v;
      step(1'b1, 1'b0, 4'd0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_A"},      32'(A),          32'h0);
      check({tag, "_B"},      32'(B),          32'h0);
      check({tag, "_opcode"}, 32'(opcode),     32'h0);
      check({tag, "_stage"},  32'(stage),      32'h0);
      check({tag, "_exec"},   32'(exec_valid), 32'h0);
   endtask

   initial begin
      n_checks    = 0;
      n_pass      = 0;
      rst         = 1'b0;
      sw          = '0;
      load_pulse  = 1'b0;
      clear_pulse = 1'b0;
      op_pulse    = 4'd0;

      // Reset for two cycles, then release
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      check_reset_vals("reset");

      // Entry sequence
      load_sw(8'h3C);
      check("entry_A", 32'(A), 32'h3C);
      check("entry_stage1", 32'(stage), 32'd1);
      load_sw(8'h05);
      check("entry_B", 32'(B), 32'h05);
      check("entry_stage2", 32'(stage), 32'd2);
      sw = 8'hEE;
      step(1'b0, 1'b0, 4'b0100);
      check("entry_opcode", 32'(opcode), 32'h4);
      check("entry_stage3", 32'(stage), 32'd3);
      check("entry_exec_hi", 32'(exec_valid), 32'd1);
      idle(1);
      check("entry_exec_lo", 32'(exec_valid), 32'd0);
      check("entry_opcode_held", 32'(opcode), 32'h4);
      check("sw_ignored_A", 32'(A), 32'h3C);

`ifdef ALU_SEQ_HOLD_TIMEOUT_EN
      // Ten idle cycles after SHOW entry clear the opcode
      idle(8);
      check("hold_9_opcode", 32'(opcode), 32'h4);
      check("hold_9_stage", 32'(stage), 32'd3);
      idle(1);
      check("expire_opcode", 32'(opcode), 32'h0);
      check("expire_stage", 32'(stage), 32'd0);
      check("expire_A", 32'(A), 32'h3C);
      check("expire_B", 32'(B), 32'h05);
      check("expire_exec", 32'(exec_valid), 32'd0);
`else
      // Without the timeout the opcode is held indefinitely
      idle(999);
      check("nohold_opcode", 32'(opcode), 32'h4);
      check("nohold_stage", 32'(stage), 32'd3);
`endif

      // Clear returns everything to zero
      step(1'b0, 1'b1, 4'd0);
      check_reset_vals("clear");

      // Invalid op patterns in OP are ignored
      load_sw(8'h11);
      load_sw(8'h22);
      step(1'b0, 1'b0, 4'b0110);
      check("multi_stage", 32'(stage), 32'd2);
      check("multi_opcode", 32'(opcode), 32'h0);
      check("multi_exec", 32'(exec_valid), 32'd0);
      step(1'b0, 1'b0, 4'b0000);
      check("zero_stage", 32'(stage), 32'd2);
      check("zero_exec", 32'(exec_valid), 32'd0);
      step(1'b0, 1'b0, 4'b0001);
      check("valid_opcode", 32'(opcode), 32'h1);
      check("valid_exec", 32'(exec_valid), 32'd1);
      check("valid_stage", 32'(stage), 32'd3);

      // Load in the same cycle as expiry: load wins
      idle(9);
      sw = 8'hA1;
      step(1'b1, 1'b0, 4'd0);
      check("ldexp_A", 32'(A), 32'hA1);
      check("ldexp_opcode", 32'(opcode), 32'h0);
      check("ldexp_stage", 32'(stage), 32'd1);
      check("ldexp_B", 32'(B), 32'h22);

      // Clear together with load in LOAD_A: clear wins
      step(1'b0, 1'b1, 4'd0);
      sw = 8'h77;
      step(1'b1, 1'b1, 4'd0);
      check("clrld_A", 32'(A), 32'h0);
      check("clrld_stage", 32'(stage), 32'd0);

      // Reset while in SHOW with the counter at 5
      load_sw(8'h3C);
      load_sw(8'h05);
      step(1'b0, 1'b0, 4'b1000);
      idle(5);
      rst = 1'b0;
      step(1'b0, 1'b0, 4'd0);
      check_reset_vals("midrst");
      rst = 1'b1;

      // After reset the next SHOW starts counting from zero; op at expiry wins
      load_sw(8'h12);
      load_sw(8'h34);
      step(1'b0, 1'b0, 4'b0010);
      idle(9);
      check("post_rst_opcode", 32'(opcode), 32'h2);
      check("post_rst_stage", 32'(stage), 32'd3);
      step(1'b0, 1'b0, 4'b0001);
      check("opexp_opcode", 32'(opcode), 32'h1);
      check("opexp_exec", 32'(exec_valid), 32'd1);
      check("opexp_stage", 32'(stage), 32'd3);
      idle(9);
      check("opexp_hold_stage", 32'(stage), 32'd3);
      idle(1);
`ifdef ALU_SEQ_HOLD_TIMEOUT_EN
      check("opexp_expire_stage", 32'(stage), 32'd0);
      check("opexp_expire_opcode", 32'(opcode), 32'h0);
`else
      check("opexp_nohold_stage", 32'(stage), 32'd3);
      check("opexp_nohold_opcode", 32'(opcode), 32'h1);
`endif
      check("final_A", 32'(A), 32'h12);
      check("final_B", 32'(B), 32'h34);
      check("final_exec", 32'(exec_valid), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream stage of the board-level ALU display top.
- Replaces direct switch/button wiring with a registered entry sequence. The user loads operand A from the switches, then operand B, then selects an operation with one debounced button pulse.
- Drives the ALU's A, B and opcode inputs, plus a stage indicator for the display top.
- Clears the opcode after a hold period, so the display falls back to showing the operands.

Parameters:
- WIDTH, 8: operand width in bits.
- HOLD_CYCLES, 100000000: cycles the opcode is held in SHOW before auto-return (1 s at 100 MHz). Must be at least 2.
- CNT_W, $clog2(HOLD_CYCLES+1): width of the hold counter (derived; do not override).

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  synchronous, active-low reset
- sw  in  WIDTH  operand switches, quasi-static
- load_pulse  in  1  one-cycle pulse, debounced "load" button
- clear_pulse  in  1  one-cycle pulse, debounced "clear" button
- op_pulse  in  4  one-cycle pulses {Up,Down,Right,Left} from the debouncers
- A  out  WIDTH  registered operand A
- B  out  WIDTH  registered operand B
- opcode  out  4  registered one-hot opcode; 4'b0000 means "no operation"
- stage  out  2  0=LOAD_A, 1=LOAD_B, 2=OP, 3=SHOW
- exec_valid  out  1  one-cycle pulse in the first cycle a new opcode is presented

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset (rst==0 at a clk edge):
  - A=0, B=0, opcode=0, exec_valid=0, hold counter=0.
  - State LOAD_A, so stage=0.
- Per-cycle event priority: clear_pulse > load_pulse > op_pulse > hold expiry.
- op is valid only if op_pulse is exactly one-hot. 4'b0000 and multi-bit patterns are ignored (no state change).
- clear_pulse (any state): next cycle A=0, B=0, opcode=0, counter=0, state LOAD_A.
- LOAD_A:
  - load_pulse -> A<=sw, state LOAD_B.
  - op_pulse ignored.
- LOAD_B:
  - load_pulse -> B<=sw, state OP.
  - op_pulse ignored.
- OP:
  - valid op -> opcode<=op_pulse, exec_valid=1 for one cycle, counter<=0, state SHOW.
  - load_pulse -> A<=sw, state LOAD_B (restarts entry and keeps the old B until overwritten).
- SHOW:
  - Counter increments every cycle.
  - Counter reaching HOLD_CYCLES-1 -> opcode<=0, counter<=0, state LOAD_A. A and B are retained so the display shows them.
  - Valid op -> opcode<=op_pulse, exec_valid pulse, counter<=0, stay in SHOW (re-execute on the same operands).
  - load_pulse -> A<=sw, opcode<=0, counter<=0, state LOAD_B. This lets the next entry start without waiting.
  - load_pulse and expiry in the same cycle: load wins (A captured, state LOAD_B).
  - Valid op and expiry in the same cycle: op wins (counter restarts).
- Latency:
  - A, B, opcode and stage update on the first edge after the pulse is sampled.
  - exec_valid is high in exactly the cycle the new opcode first appears on the output.
- exec_valid is 0 in every other cycle, including after clear and after expiry.
- Counter never exceeds HOLD_CYCLES-1 and is held at 0 outside SHOW.
- sw is sampled only on load_pulse. Changes to sw at other times have no effect.

Optional Feature:
- Macro: ALU_SEQ_HOLD_TIMEOUT_EN.
- Defined: the SHOW hold timeout operates as described above.
- Undefined:
  - No hold counter is synthesised.
  - SHOW is left only via clear_pulse or load_pulse; opcode is held indefinitely.
  - Valid op in SHOW still updates opcode and pulses exec_valid.

Test Plan:
- Reset check: rst=0 for 2 cycles then release -> A=0, B=0, opcode=0, stage=0, exec_valid=0.
- Entry sequence: sw=8'h3C, load_pulse; sw=8'h05, load_pulse; op_pulse=4'b0100 -> A=8'h3C, B=8'h05, opcode=4'b0100, stage=3, exec_valid high for exactly 1 cycle.
- Timeout (HOLD_CYCLES=10, macro defined): after entering SHOW, idle 10 cycles -> opcode=0, stage=0, A and B unchanged. Repeat with the macro undefined -> opcode still 4'b0100 after 1000 cycles.
- Invalid op: in OP, op_pulse=4'b0110, then 4'b0000 -> state stays 2, opcode=0, no exec_valid. Then op_pulse=4'b0001 -> opcode=4'b0001.
- Collisions:
  - In SHOW, load_pulse with sw=8'hA1 in the same cycle as expiry -> A=8'hA1, opcode=0, stage=1.
  - clear_pulse together with load_pulse in LOAD_A -> A=0, stage=0.
- Reset mid-operation: rst=0 during SHOW with counter at 5 -> next cycle all outputs at reset values, stage=0. After release, the counter restarts from 0 on the next SHOW entry.
